// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_pkg
//  Purpose  : Segment codes, digit-common patterns and capture-FSM types that
//             are shared between the FND display driver and the capture block.
//  Revision : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    // Active-low {dp,g,f,e,d,c,b,a} segment codes for the decimal digits
    localparam logic [7:0] SEG_0     = 8'hc0;
    localparam logic [7:0] SEG_1     = 8'hf9;
    localparam logic [7:0] SEG_2     = 8'ha4;
    localparam logic [7:0] SEG_3     = 8'hb0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hf8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hff;

    // Active-low digit commons: exactly one position driven at a time
    localparam logic [3:0] COM_ONES      = 4'b1110;
    localparam logic [3:0] COM_TENS      = 4'b1101;
    localparam logic [3:0] COM_HUNDREDS  = 4'b1011;
    localparam logic [3:0] COM_THOUSANDS = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_t;

    // True when exactly one common is driven low
    function automatic logic com_is_valid(input logic [3:0] com);
        return (com == COM_ONES) || (com == COM_TENS) ||
               (com == COM_HUNDREDS) || (com == COM_THOUSANDS);
    endfunction

    // Digit position selected by a valid common (0 = ones .. 3 = thousands)
    function automatic logic [1:0] com_to_pos(input logic [3:0] com);
        logic [1:0] pos;
        pos = 2'd0;
        case (com)
            COM_TENS:      pos = 2'd1;
            COM_HUNDREDS:  pos = 2'd2;
            COM_THOUSANDS: pos = 2'd3;
            default:       pos = 2'd0;
        endcase
        return pos;
    endfunction

    // Four BCD digits to binary; every term is widened to 14 bits first
    function automatic logic [13:0] bcd4_to_bin(input logic [3:0] d1,
                                                input logic [3:0] d10,
                                                input logic [3:0] d100,
                                                input logic [3:0] d1000);
        return 14'(d1) + (14'(d10) * 14'd10) + (14'(d100) * 14'd100) +
               (14'(d1000) * 14'd1000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_seg_decode
//  Purpose  : Combinational active-low 7-segment to BCD decoder. A blank
//             display reads as 0; any other unknown pattern clears ok.
//  Revision : 1.0 - initial release
// ============================================================================
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] digit,
    output logic       ok
);

    // Table lookup; unknown patterns report digit 0 with ok low
    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = 4'd0;
            default: begin
                digit = 4'd0;
                ok    = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fnd_capture.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_capture
//  Purpose  : Snoops a multiplexed 4-digit FND bus, latches each digit once it
//             has been stable, and publishes complete frames as BCD + binary.
//  Revision : 1.0 - initial release
// ============================================================================
module fnd_capture
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  fnd_data,
    input  logic [3:0]  fnd_com,
    output logic [3:0]  digit_1,
    output logic [3:0]  digit_10,
    output logic [3:0]  digit_100,
    output logic [3:0]  digit_1000,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        seg_err
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       data_sync [SYNC_STAGES];
    logic [3:0]       com_sync  [SYNC_STAGES];
    logic [7:0]       data_s;
    logic [3:0]       com_s;
    logic [7:0]       prev_data;
    logic [3:0]       prev_com;
    logic             changed;
    logic             com_ok;

    cap_state_t       state;
    cap_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             latch;

    logic [3:0]       dec_digit;
    logic             dec_ok;
    logic [1:0]       pos;
    logic [3:0]       pos_onehot;
    logic [3:0][3:0]  shadow;
    logic [3:0]       mask;
    logic             frame_done;
    logic [3:0]       mask_base;

    // Input synchronizers; idle-high so the bus reads as "nothing driven"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= 8'hff;
                com_sync[i]  <= 4'hf;
            end
        end else begin
            data_sync[0] <= fnd_data;
            com_sync[0]  <= fnd_com;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
                com_sync[i]  <= com_sync[i-1];
            end
        end
    end

    assign data_s  = data_sync[SYNC_STAGES-1];
    assign com_s   = com_sync[SYNC_STAGES-1];
    assign changed = (data_s != prev_data) || (com_s != prev_com);
    assign com_ok  = com_is_valid(com_s);

    // One-cycle-old copy of the synchronized bus for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_data <= 8'hff;
            prev_com  <= 4'hf;
        end else begin
            prev_data <= data_s;
            prev_com  <= com_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (com_ok) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (changed)               state_nxt = com_ok ? ST_SETTLE : ST_IDLE;
                else if (cnt == CNT_LAST)  state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (changed)               state_nxt = com_ok ? ST_SETTLE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: counter control and the single-cycle latch strobe
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        latch     = 1'b0;
        case (state)
            ST_IDLE:   cnt_clear = 1'b1;
            ST_SETTLE: begin
                if (changed)              cnt_clear = 1'b1;
                else if (cnt == CNT_LAST) latch     = 1'b1;
                else                      cnt_inc   = 1'b1;
            end
            ST_HOLD:   cnt_clear = 1'b1;
            default:   cnt_clear = 1'b1;
        endcase
    end

    // Stability counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    fnd_seg_decode u_seg_decode (
        .seg   (data_s),
        .digit (dec_digit),
        .ok    (dec_ok)
    );

    assign pos        = com_to_pos(com_s);
    assign pos_onehot = 4'b0001 << pos;
    assign frame_done = (mask == 4'b1111);
    // A completing frame clears first, so a same-cycle latch starts the next one
    assign mask_base  = frame_done ? 4'b0000 : mask;

    // Shadow digits, capture mask and the undecodable-pattern pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            mask    <= 4'b0000;
            seg_err <= 1'b0;
        end else begin
            seg_err <= latch && !dec_ok;
            if (latch && dec_ok) begin
                shadow[pos] <= dec_digit;
                mask        <= mask_base | pos_onehot;
            end else begin
                mask        <= mask_base;
            end
        end
    end

    // Publish a complete frame; outputs hold their value between frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_1     <= 4'd0;
            digit_10    <= 4'd0;
            digit_100   <= 4'd0;
            digit_1000  <= 4'd0;
            value       <= 14'd0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                digit_1    <= shadow[0];
                digit_10   <= shadow[1];
                digit_100  <= shadow[2];
                digit_1000 <= shadow[3];
                value      <= bcd4_to_bin(shadow[0], shadow[1], shadow[2], shadow[3]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_capture
//  Purpose  : Self-checking bench for fnd_capture using a frame scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_capture;

    localparam int S  = 16;
    localparam int SY = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  fnd_data = 8'hff;
    logic [3:0]  fnd_com  = 4'hf;
    logic [3:0]  digit_1, digit_10, digit_100, digit_1000;
    logic [13:0] value;
    logic        frame_valid, seg_err;

    typedef struct {
        int d1000;
        int d100;
        int d10;
        int d1;
        int value;
    } frame_t;

    frame_t      exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          frame_cnt   = 0;
    int          seg_cnt     = 0;
    logic [29:0] last_out    = '0;

    fnd_capture #(.STABLE_CYCLES(S), .SYNC_STAGES(SY)) dut (
        .clk         (clk),
        .reset       (reset),
        .fnd_data    (fnd_data),
        .fnd_com     (fnd_com),
        .digit_1     (digit_1),
        .digit_10    (digit_10),
        .digit_100   (digit_100),
        .digit_1000  (digit_1000),
        .value       (value),
        .frame_valid (frame_valid),
        .seg_err     (seg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hc0;  1: return 8'hf9;  2: return 8'ha4;  3: return 8'hb0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hf8;
            8: return 8'h80;  9: return 8'h90;  default: return 8'hff;
        endcase
    endfunction

    function automatic void push_frame(input int a, input int b, input int c, input int d);
        frame_t f;
        f.d1000 = a; f.d100 = b; f.d10 = c; f.d1 = d;
        f.value = a * 1000 + b * 100 + c * 10 + d;
        exp_q.push_back(f);
    endfunction

    // Scoreboard: pop on every frame pulse, and outputs must not move otherwise
    always @(negedge clk) begin
        frame_t      e;
        logic [29:0] act;
        logic [29:0] expv;
        act = {digit_1000, digit_100, digit_10, digit_1, value};
        if (reset) begin
            last_out = '0;
        end else begin
            if (seg_err) seg_cnt++;
            if (frame_valid) begin
                frame_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame: got value=%0d digits=%h, expected no frame",
                             value, act[29:14]);
                end else begin
                    e = exp_q.pop_front();
                    expv = {e.d1000[3:0], e.d100[3:0], e.d10[3:0], e.d1[3:0], e.value[13:0]};
                    if (act !== expv) begin
                        miscompares++;
                        $display("FAIL frame: got digits=%h value=%0d, expected digits=%h value=%0d",
                                 act[29:14], act[13:0], expv[29:14], expv[13:0]);
                    end
                end
                last_out = act;
            end else begin
                vectors++;
                if (act !== last_out) begin
                    miscompares++;
                    $display("FAIL outputs_stable: got %h without frame_valid, expected %h",
                             act, last_out);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] com, input logic [7:0] seg, input int n);
        fnd_com  = com;
        fnd_data = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(4'b1111, 8'hff, n);
    endtask

    task automatic scan(input int a, input int b, input int c, input int d, input int hold);
        drive(4'b0111, seg_of(a), hold);
        drive(4'b1011, seg_of(b), hold);
        drive(4'b1101, seg_of(c), hold);
        drive(4'b1110, seg_of(d), hold);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d frames outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(4);
        vectors++; if (digit_1 !== 4'd0)     begin miscompares++; $display("FAIL reset_d1: got %0d, expected 0", digit_1); end
        vectors++; if (digit_10 !== 4'd0)    begin miscompares++; $display("FAIL reset_d10: got %0d, expected 0", digit_10); end
        vectors++; if (digit_100 !== 4'd0)   begin miscompares++; $display("FAIL reset_d100: got %0d, expected 0", digit_100); end
        vectors++; if (digit_1000 !== 4'd0)  begin miscompares++; $display("FAIL reset_d1000: got %0d, expected 0", digit_1000); end
        vectors++; if (value !== 14'd0)      begin miscompares++; $display("FAIL reset_value: got %0d, expected 0", value); end
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b, expected 0", frame_valid); end
        vectors++; if (seg_err !== 1'b0)     begin miscompares++; $display("FAIL reset_segerr: got %b, expected 0", seg_err); end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_scan_1234;
        push_frame(1, 2, 3, 4);
        scan(1, 2, 3, 4, 100);
        idle(20);
        wait_drain("scan_1234");
    endtask

    task automatic test_short_hold;
        int f0, s0;
        f0 = frame_cnt; s0 = seg_cnt;
        scan(5, 6, 7, 8, S - 2);
        idle(40);
        vectors++; if (frame_cnt != f0) begin miscompares++; $display("FAIL short_frame: got %0d frames, expected 0", frame_cnt - f0); end
        vectors++; if (seg_cnt != s0)   begin miscompares++; $display("FAIL short_segerr: got %0d pulses, expected 0", seg_cnt - s0); end
    endtask

    task automatic test_toggle;
        int first, pulses;
        drive(4'b1110, 8'h00, 12);
        fnd_data = 8'h01;
        first = -1; pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (seg_err) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        vectors++; if (first != SY + S + 1) begin miscompares++; $display("FAIL toggle_latency: got %0d, expected %0d", first, SY + S + 1); end
        vectors++; if (pulses != 1)         begin miscompares++; $display("FAIL toggle_pulses: got %0d, expected 1", pulses); end
        idle(20);
    endtask

    task automatic test_bad_com;
        int s0, f0;
        s0 = seg_cnt; f0 = frame_cnt;
        drive(4'b1100, 8'h00, 100);
        drive(4'b1111, 8'h00, 100);
        drive(4'b1100, seg_of(3), 100);
        idle(20);
        vectors++; if (seg_cnt != s0)   begin miscompares++; $display("FAIL badcom_segerr: got %0d pulses, expected 0", seg_cnt - s0); end
        vectors++; if (frame_cnt != f0) begin miscompares++; $display("FAIL badcom_frame: got %0d frames, expected 0", frame_cnt - f0); end
    endtask

    task automatic test_seg_err;
        int s0, f0;
        s0 = seg_cnt; f0 = frame_cnt;
        drive(4'b0111, seg_of(5), 100);
        drive(4'b1011, 8'h00, 100);
        drive(4'b1101, seg_of(6), 100);
        drive(4'b1110, seg_of(7), 100);
        idle(30);
        vectors++; if (seg_cnt - s0 != 1) begin miscompares++; $display("FAIL segerr_count: got %0d pulses, expected 1", seg_cnt - s0); end
        vectors++; if (frame_cnt != f0)   begin miscompares++; $display("FAIL segerr_early_frame: got %0d frames, expected 0", frame_cnt - f0); end
        push_frame(5, 8, 6, 7);
        drive(4'b1011, seg_of(8), 100);
        idle(20);
        wait_drain("segerr");
    endtask

    task automatic test_overwrite;
        push_frame(6, 3, 2, 1);
        drive(4'b0111, seg_of(3), 100);
        drive(4'b1011, seg_of(3), 100);
        drive(4'b0111, seg_of(6), 100);
        drive(4'b1101, seg_of(2), 100);
        drive(4'b1110, seg_of(1), 100);
        idle(20);
        wait_drain("overwrite");
    endtask

    task automatic test_back_to_back;
        push_frame(2, 0, 0, 9);
        push_frame(8, 7, 6, 5);
        drive(4'b0111, seg_of(2), 60);
        drive(4'b1011, 8'hff, 60);
        drive(4'b1101, seg_of(0), 60);
        drive(4'b1110, seg_of(9), 60);
        scan(8, 7, 6, 5, 60);
        idle(20);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_midframe;
        int f0;
        drive(4'b0111, seg_of(7), 100);
        drive(4'b1011, seg_of(7), 100);
        drive(4'b1101, seg_of(7), 100);
        #2 reset = 1'b1;
        fnd_com = 4'b1111; fnd_data = 8'hff;
        repeat (3) @(negedge clk);
        vectors++; if ({digit_1000, digit_100, digit_10, digit_1} !== 16'h0) begin miscompares++; $display("FAIL midreset_digits: got %h, expected 0000", {digit_1000, digit_100, digit_10, digit_1}); end
        vectors++; if (value !== 14'd0) begin miscompares++; $display("FAIL midreset_value: got %0d, expected 0", value); end
        reset = 1'b0;
        idle(5);
        f0 = frame_cnt;
        drive(4'b1110, seg_of(9), 100);
        idle(20);
        vectors++; if (frame_cnt != f0) begin miscompares++; $display("FAIL midreset_stale_frame: got %0d frames, expected 0", frame_cnt - f0); end
        vectors++; if (value !== 14'd0) begin miscompares++; $display("FAIL midreset_hold0: got %0d, expected 0", value); end
        push_frame(9, 9, 9, 9);
        drive(4'b0111, seg_of(9), 100);
        drive(4'b1011, seg_of(9), 100);
        drive(4'b1101, seg_of(9), 100);
        idle(20);
        wait_drain("midreset_9999");
        vectors++; if (value !== 14'd9999) begin miscompares++; $display("FAIL value_9999: got %0d, expected 9999", value); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_scan_1234;
        test_short_hold;
        test_toggle;
        test_bad_com;
        test_seg_err;
        test_overwrite;
        test_back_to_back;
        test_reset_midframe;
        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
